pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter NB_CTRL, default 12, control-bundle width (bit 0 = regWrite, bit 2 = memWrite).
REQ-002 SHALL have parameter NB_DATA, default 176, payload width (PC, PC+4, rs1/rs2 data, imm, addresses, func fields).
REQ-003 SHALL have parameter NB_CNT, default 16, width of the stall and flush counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1, upstream entry valid.
REQ-007 SHALL have port o_ready, output, 1, stage can accept an entry this cycle.
REQ-008 SHALL have port i_ctrl, input, NB_CTRL, upstream control bundle.
REQ-009 SHALL have port i_data, input, NB_DATA, upstream payload.
REQ-010 SHALL have port o_valid, output, 1, downstream entry valid.
REQ-011 SHALL have port i_ready, input, 1, downstream accepts this cycle.
REQ-012 SHALL have port o_ctrl, output, NB_CTRL, head-entry control bundle.
REQ-013 SHALL have port o_data, output, NB_DATA, head-entry payload.
REQ-014 SHALL have port i_flush, input, 1, squash all held entries.
REQ-015 SHALL have port o_occupancy, output, 2, entries held (0..2).
REQ-016 SHALL have port o_stall_cnt, output, NB_CNT, saturating count of back-pressure cycles.
REQ-017 SHALL have port o_flush_cnt, output, NB_CNT, saturating count of flush cycles.

Function
REQ-018 SHALL hold a main entry and a skid entry; states: EMPTY (0 held), ONE (main only), TWO (main and skid).
REQ-019 SHALL define in_fire = i_valid & o_ready and out_fire = o_valid & i_ready.
REQ-020 SHALL drive o_valid = (state != EMPTY), o_ready = (state != TWO), and o_occupancy = entries held; all decoded from registered state only, with no combinational path from i_ready or i_valid.
REQ-021 SHALL drive o_ctrl and o_data from the main entry.
REQ-022 SHALL make these transitions when i_flush = 0:
  - EMPTY, in_fire -> ONE; main <= input.
  - ONE, in_fire & out_fire -> ONE; main <= input.
  - ONE, in_fire & !i_ready -> TWO; skid <= input, main held.
  - ONE, !in_fire & out_fire -> EMPTY.
  - TWO, out_fire -> ONE; main <= skid.
  - Otherwise the state and both entries are held.
REQ-023 SHALL give one cycle of latency: an entry accepted at edge N is presented on o_valid/o_ctrl/o_data after edge N.
REQ-024 SHALL preserve order; entries are never dropped or duplicated without i_flush.
REQ-025 SHALL, when i_flush = 1, go to EMPTY at the next edge and zero the main and skid ctrl and data; flush overrides any simultaneous in_fire or out_fire, and the entry offered that cycle is discarded.
REQ-026 SHALL force o_ctrl to all-zero whenever o_valid = 0, so an empty stage presents a bubble (no regWrite or memWrite).
REQ-027 SHALL hold o_data unchanged while the stage is EMPTY (after reset or flush, zero).
REQ-028 SHALL increment o_stall_cnt on every edge where o_valid = 1, i_ready = 0 and i_flush = 0; it saturates at all-ones and never wraps.
REQ-029 SHALL increment o_flush_cnt on every edge where i_flush = 1, regardless of state; it saturates at all-ones.

Reset
REQ-030 SHALL, on i_rst_n = 0, immediately set: state EMPTY, o_valid 0, o_ready 1, o_occupancy 0, o_ctrl 0, o_data 0, skid 0, and both counters 0.
REQ-031 SHALL let reset override flush and all traffic, including mid-operation in state TWO; the first entry may be accepted on the first edge after release.

Verification
REQ-032 SHALL cover streaming: i_ready = 1, i_valid = 1 for 4 cycles with data 1,2,3,4 -> o_data 1,2,3,4 on consecutive cycles one cycle later; o_stall_cnt stays 0.
REQ-033 SHALL cover skid fill: in ONE holding A with i_ready = 0, offer B -> occupancy 2, o_ready 0, o_data A; raise i_ready -> A, then B, then EMPTY; o_stall_cnt = 1.
REQ-034 SHALL cover flush in TWO with simultaneous i_valid = 1 -> next cycle o_valid 0, o_ctrl 0, o_data 0, occupancy 0, o_ready 1, o_flush_cnt + 1; the offered entry is never output.
REQ-035 SHALL cover saturation: with NB_CNT = 4, hold o_valid = 1 and i_ready = 0 for 20 cycles -> o_stall_cnt = 15 and holds.
REQ-036 SHALL cover reset in state TWO: assert i_rst_n = 0 between edges -> outputs match REQ-030 before the next edge.
REQ-037 SHALL cover bubble masking: EMPTY with i_ctrl = 12'hFFF and i_valid = 0 -> o_ctrl 0 and o_valid 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Two-entry (main + skid) pipeline register between two pipeline stages.
//   Valid/ready handshake on both sides. Every output is decoded from registered
//   state only, so i_valid and i_ready have no combinational path to any output.
//   An empty stage presents a bubble: o_ctrl is forced to zero.
//
// Ports
//   clk          : clock; all state changes on its rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_valid      : upstream entry valid
//   o_ready      : stage can accept an entry this cycle
//   i_ctrl       : upstream control bundle (bit 0 regWrite, bit 2 memWrite)
//   i_data       : upstream payload
//   o_valid      : downstream entry valid
//   i_ready      : downstream accepts this cycle
//   o_ctrl       : head-entry control bundle, zero when empty
//   o_data       : head-entry payload, held while empty
//   i_flush      : squash all held entries
//   o_occupancy  : number of entries held (0..2)
//   o_stall_cnt  : saturating count of back-pressure cycles
//   o_flush_cnt  : saturating count of flush cycles
module pipe_stage_reg #(
    parameter int NB_CTRL = 12,
    parameter int NB_DATA = 176,
    parameter int NB_CNT  = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data,
    input  logic               i_flush,
    output logic [1:0]         o_occupancy,
    output logic [NB_CNT-1:0]  o_stall_cnt,
    output logic [NB_CNT-1:0]  o_flush_cnt
);

    // State encoding equals the number of held entries, so occupancy is the state.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]         state;
    logic [NB_CTRL-1:0] main_ctrl;
    logic [NB_DATA-1:0] main_data;
    logic [NB_CTRL-1:0] skid_ctrl;
    logic [NB_DATA-1:0] skid_data;
    logic [NB_CNT-1:0]  stall_cnt;
    logic [NB_CNT-1:0]  flush_cnt;

    logic in_fire;
    logic out_fire;

    assign o_valid     = (state != EMPTY);
    assign o_ready     = (state != TWO);
    assign o_occupancy = state;
    assign o_ctrl      = o_valid ? main_ctrl : '0;
    assign o_data      = main_data;
    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (i_flush) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= ONE;
                        main_ctrl <= i_ctrl;
                        main_data <= i_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= i_ctrl;
                        main_data <= i_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry behind the head.
                        state     <= TWO;
                        skid_ctrl <= i_ctrl;
                        skid_data <= i_data;
                    end else if (out_fire) begin
                        // Payload left in main is kept so o_data holds while empty.
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state     <= ONE;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (o_valid && !i_ready && !i_flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + NB_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_cnt <= '0;
        end else if (i_flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + NB_CNT'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed scenarios plus randomized traffic for pipe_stage_reg, compared
//   against a queue-based reference model of the two-entry stage.
module tb_pipe_stage_reg;

    localparam int NB_CTRL = 12;
    localparam int NB_DATA = 176;
    localparam int NB_CNT  = 4;
    localparam int CNT_MAX = (1 << NB_CNT) - 1;

    logic               clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_DATA-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [NB_CTRL-1:0] o_ctrl;
    logic [NB_DATA-1:0] o_data;
    logic               i_flush;
    logic [1:0]         o_occupancy;
    logic [NB_CNT-1:0]  o_stall_cnt;
    logic [NB_CNT-1:0]  o_flush_cnt;

    pipe_stage_reg #(
        .NB_CTRL(NB_CTRL),
        .NB_DATA(NB_DATA),
        .NB_CNT (NB_CNT)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_ctrl     (i_ctrl),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_ctrl     (o_ctrl),
        .o_data     (o_data),
        .i_flush    (i_flush),
        .o_occupancy(o_occupancy),
        .o_stall_cnt(o_stall_cnt),
        .o_flush_cnt(o_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB_CTRL-1:0] c;
        logic [NB_DATA-1:0] d;
    } ent_t;

    // Reference model: FIFO of held entries, last presented payload, counters.
    ent_t               q[$];
    logic [NB_DATA-1:0] m_data;
    int unsigned        m_stall;
    int unsigned        m_flush;

    int unsigned n_tests;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        logic [NB_CTRL-1:0] exp_ctrl;
        exp_ctrl = (q.size() != 0) ? q[0].c : '0;
        check({where, ".valid"}, 192'(o_valid), 192'(q.size() != 0));
        check({where, ".ready"}, 192'(o_ready), 192'(q.size() < 2));
        check({where, ".occ"},   192'(o_occupancy), 192'(q.size()));
        check({where, ".ctrl"},  192'(o_ctrl), 192'(exp_ctrl));
        check({where, ".data"},  192'(o_data), 192'(m_data));
        check({where, ".stall"}, 192'(o_stall_cnt), 192'(m_stall));
        check({where, ".flush"}, 192'(o_flush_cnt), 192'(m_flush));
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Drive inputs for one cycle, advance the model across the edge, then check.
    task automatic step(input string where, input logic v, input logic [NB_CTRL-1:0] c,
                        input logic [NB_DATA-1:0] d, input logic rdy, input logic fl);
        logic acc;
        logic pop;
        ent_t e;
        i_valid = v;
        i_ctrl  = c;
        i_data  = d;
        i_ready = rdy;
        i_flush = fl;
        acc = v && (q.size() < 2);
        pop = rdy && (q.size() != 0);
        e.c = c;
        e.d = d;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            m_data = '0;
            if (m_flush < CNT_MAX) m_flush++;
        end else begin
            if (q.size() != 0 && !rdy && m_stall < CNT_MAX) m_stall++;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() != 0) m_data = q[0].d;
        check_outputs(where);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    function automatic logic [NB_DATA-1:0] rand_data();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r[NB_DATA-1:0];
    endfunction

    logic [NB_DATA-1:0] da;
    logic [NB_DATA-1:0] db;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_valid = 1'b0;
        i_ctrl  = '0;
        i_data  = '0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        model_reset();
        do_reset();

        // Bubble masking: empty stage with all-ones control offered but not valid.
        step("bubble", 1'b0, 12'hFFF, rand_data(), 1'b1, 1'b0);
        check("bubble.ctrl0", 192'(o_ctrl), 192'(0));

        // Streaming 1..4 with downstream always ready.
        for (int i = 1; i <= 4; i++)
            step("stream", 1'b1, 12'(i), NB_DATA'(i), 1'b1, 1'b0);
        step("stream", 1'b0, '0, '0, 1'b1, 1'b0);
        check("stream.stall0", 192'(o_stall_cnt), 192'(0));

        // Skid fill: A held with downstream stalled, then B offered.
        do_reset();
        da = rand_data();
        db = rand_data();
        step("skid", 1'b1, 12'h005, da, 1'b0, 1'b0);
        step("skid", 1'b1, 12'h001, db, 1'b0, 1'b0);
        check("skid.occ2", 192'(o_occupancy), 192'(2));
        check("skid.headA", 192'(o_data), 192'(da));
        step("skid", 1'b0, '0, '0, 1'b1, 1'b0);
        check("skid.headB", 192'(o_data), 192'(db));
        step("skid", 1'b0, '0, '0, 1'b1, 1'b0);
        check("skid.stall1", 192'(o_stall_cnt), 192'(1));

        // Flush in TWO while a new entry is offered.
        step("flush", 1'b1, 12'h004, rand_data(), 1'b0, 1'b0);
        step("flush", 1'b1, 12'h004, rand_data(), 1'b0, 1'b0);
        step("flush", 1'b1, 12'hFFF, rand_data(), 1'b1, 1'b1);
        check("flush.data0", 192'(o_data), 192'(0));
        step("flush", 1'b0, '0, '0, 1'b1, 1'b0);

        // Stall counter saturation.
        do_reset();
        step("sat", 1'b1, 12'h001, rand_data(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step("sat", 1'b0, '0, '0, 1'b0, 1'b0);
        check("sat.stall15", 192'(o_stall_cnt), 192'(CNT_MAX));

        // Asynchronous reset between edges while in TWO.
        do_reset();
        step("rst2", 1'b1, 12'h001, rand_data(), 1'b0, 1'b0);
        step("rst2", 1'b1, 12'h004, rand_data(), 1'b0, 1'b0);
        #2;
        do_reset();
        step("rst2", 1'b1, 12'h007, rand_data(), 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 9) < 7), 12'($urandom), rand_data(),
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
